// File: rtl/spi_cfg_pkg.sv
// Shared constants, state encoding and frame helper for the SPI configuration sequencer.
// The peripheral only accepts frames of exactly FRAME_W bits with the write bit set.
package spi_cfg_pkg;

  localparam int FRAME_W = 16;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] ADDR_MAX       = 7'h04;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_HIGH  = 3'd2;
  localparam state_t ST_LOW   = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [6:0] addr,
                                                    input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request FIFO with wrap-bit pointers; a push into a full FIFO is
// refused even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Queues register-write requests and serialises each as a 16-bit SPI mode-0
// write frame; requests addressing beyond ADDR_MAX are dropped with err_drop.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       frame_done,
  output logic       err_drop
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  logic [14:0]        fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [6:0]         head_addr;
  logic [7:0]         head_data;
  state_t             state;
  logic [7:0]         div_cnt;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;

  sync_fifo #(
    .WIDTH (15),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   ({req_addr, req_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign head_addr = fifo_dout[14:8];
  assign head_data = fifo_dout[7:0];
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  // COPI only moves on the falling SCLK edge, so it is stable for the whole
  // high phase that surrounds each rising edge the peripheral samples on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      SCLK       <= 1'b0;
      COPI       <= 1'b0;
      nCS        <= 1'b1;
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_drop   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_addr > ADDR_MAX) begin
              err_drop <= 1'b1;
            end else begin
              shreg   <= make_frame(head_addr, head_data);
              COPI    <= WRITE_BIT;
              nCS     <= 1'b0;
              bit_cnt <= '0;
              div_cnt <= DIV_LOAD;
              state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (div_cnt == 8'd0) begin
            SCLK    <= 1'b1;
            div_cnt <= DIV_LOAD;
            state   <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_cnt == 8'd0) begin
            SCLK    <= 1'b0;
            COPI    <= shreg[FRAME_W-2];
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            div_cnt <= DIV_LOAD;
            state   <= ST_LOW;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_LOW: begin
          if (div_cnt == 8'd0) begin
            if (bit_cnt == 5'(FRAME_W)) begin
              nCS        <= 1'b1;
              frame_done <= 1'b1;
              div_cnt    <= GAP_LOAD;
              state      <= ST_GAP;
            end else begin
              SCLK    <= 1'b1;
              div_cnt <= DIV_LOAD;
              state   <= ST_HIGH;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (div_cnt == 8'd0) state <= ST_IDLE;
          else                 div_cnt <= div_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed frames, negedge monitors
// decode the SPI pins, pop the queue and model the peripheral register file.
module tb_spi_cfg_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int CS_GAP   = 8;
  localparam int LOW_CYC  = 132;
  localparam int PERIOD   = 141;
  localparam int LOW_CYC3 = 99;

  typedef struct packed {
    logic        drop;
    logic [15:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, SCLK, COPI, nCS, busy, frame_done, err_drop;

  logic       req_valid3 = 1'b0;
  logic [6:0] req_addr3 = '0;
  logic [7:0] req_data3 = '0;
  logic       req_ready3, sclk3, copi3, ncs3, busy3, frame_done3, err_drop3;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  exp_t exp_q[$];
  exp_t exp3_q[$];
  int   fall_q[$];
  logic [7:0] preg [5];
  logic [7:0] preg3 [5];

  spi_cfg_sequencer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .busy(busy), .frame_done(frame_done), .err_drop(err_drop)
  );

  spi_cfg_sequencer #(.CLK_DIV(3), .CS_GAP(4), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .req_data(req_data3), .SCLK(sclk3), .COPI(copi3), .nCS(ncs3),
    .busy(busy3), .frame_done(frame_done3), .err_drop(err_drop3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got hang, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor for the default-parameter instance.
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  int          low_cnt = 0, rise_cnt = 0;
  logic [15:0] cap = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ncs = 1'b1; prev_sclk = 1'b0; low_cnt = 0; rise_cnt = 0;
    end else begin
      if (!nCS) begin
        if (prev_ncs) begin
          low_cnt = 0; rise_cnt = 0; cap = '0;
          fall_q.push_back(cyc);
        end
        low_cnt++;
        if (SCLK && !prev_sclk) begin
          cap = {cap[14:0], COPI};
          rise_cnt++;
        end
      end else if (!prev_ncs) begin
        check_output("frame_done at nCS rise", 32'(frame_done), 32'd1);
        check_output("nCS low cycles", 32'(low_cnt), 32'(LOW_CYC));
        check_output("SCLK rises per frame", 32'(rise_cnt), 32'd16);
        if (exp_q.size() == 0) begin
          check_output("unexpected frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("frame where drop expected", 32'(e.drop), 32'd0);
          check_output("frame word", 32'(cap), 32'(e.frame));
        end
        if (rise_cnt == 16 && cap[15] && cap[14:8] <= 7'h04) preg[int'(cap[14:8])] = cap[7:0];
      end
      if (frame_done && !(nCS && !prev_ncs)) check_output("stray frame_done", 32'd1, 32'd0);
      if (err_drop) begin
        check_output("nCS high during drop", 32'(nCS), 32'd1);
        if (exp_q.size() == 0) begin
          check_output("unexpected err_drop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("drop where frame expected", 32'(e.drop), 32'd1);
        end
      end
      prev_ncs = nCS; prev_sclk = SCLK;
    end
  end

  // Monitor for the CLK_DIV=3 / CS_GAP=4 instance.
  logic        prev_ncs3 = 1'b1, prev_sclk3 = 1'b0;
  int          low_cnt3 = 0, rise_cnt3 = 0;
  logic [15:0] cap3 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ncs3 = 1'b1; prev_sclk3 = 1'b0;
    end else begin
      if (!ncs3) begin
        if (prev_ncs3) begin
          low_cnt3 = 0; rise_cnt3 = 0; cap3 = '0;
        end
        low_cnt3++;
        if (sclk3 && !prev_sclk3) begin
          cap3 = {cap3[14:0], copi3};
          rise_cnt3++;
        end
      end else if (!prev_ncs3) begin
        check_output("div3 nCS low cycles", 32'(low_cnt3), 32'(LOW_CYC3));
        check_output("div3 frame_done", 32'(frame_done3), 32'd1);
        if (exp3_q.size() == 0) begin
          check_output("div3 unexpected frame", 32'd1, 32'd0);
        end else begin
          e = exp3_q.pop_front();
          check_output("div3 frame word", 32'(cap3), 32'(e.frame));
        end
        if (rise_cnt3 == 16 && cap3[15] && cap3[14:8] <= 7'h04) preg3[int'(cap3[14:8])] = cap3[7:0];
      end
      prev_ncs3 = ncs3; prev_sclk3 = sclk3;
    end
  end

  task automatic apply_stimulus(input logic [6:0] a, input logic [7:0] d,
                                input logic [15:0] frame, input logic drop,
                                output logic stalled);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; stalled = 1'b0;
    while (!req_ready && n < 2000) begin
      stalled = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check_output("req_ready timeout", 32'd0, 32'd1);
    end else begin
      req_cyc = cyc;
      exp_q.push_back('{drop, frame});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!frame_done) check_output("frame_done timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_output("busy drops when drained", 32'(busy), 32'd0);
  endtask

  initial begin
    logic st;
    int   base, n, rises;
    logic ps;
    for (int i = 0; i < 5; i++) begin
      preg[i] = 8'h00;
      preg3[i] = 8'h00;
    end

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset SCLK", 32'(SCLK), 32'd0);
    check_output("reset COPI", 32'(COPI), 32'd0);
    check_output("reset nCS", 32'(nCS), 32'd1);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset frame_done", 32'(frame_done), 32'd0);
    check_output("reset err_drop", 32'(err_drop), 32'd0);
    check_output("reset req_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;

    // Single write to PWM duty
    apply_stimulus(7'h04, 8'hA5, 16'h84A5, 1'b0, st);
    wait_frame_done();
    check_output("request to nCS low latency", 32'(fall_q[fall_q.size()-1] - req_cyc), 32'd2);
    repeat (CS_GAP - 1) @(negedge clk);
    check_output("busy in last GAP cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("busy after GAP->IDLE", 32'(busy), 32'd0);
    check_output("periph pwm_duty", 32'(preg[4]), 32'hA5);

    // Six back-to-back requests overflow the 4-entry FIFO
    apply_stimulus(7'h00, 8'h11, 16'h8011, 1'b0, st);
    check_output("burst stall 1", 32'(st), 32'd0);
    apply_stimulus(7'h01, 8'h22, 16'h8122, 1'b0, st);
    check_output("burst stall 2", 32'(st), 32'd0);
    apply_stimulus(7'h02, 8'h33, 16'h8233, 1'b0, st);
    check_output("burst stall 3", 32'(st), 32'd0);
    apply_stimulus(7'h03, 8'h44, 16'h8344, 1'b0, st);
    check_output("burst stall 4", 32'(st), 32'd0);
    apply_stimulus(7'h04, 8'h55, 16'h8455, 1'b0, st);
    check_output("burst stall 5", 32'(st), 32'd0);
    apply_stimulus(7'h00, 8'h66, 16'h8066, 1'b0, st);
    check_output("burst stall 6 (full)", 32'(st), 32'd1);
    wait_idle();
    base = fall_q.size() - 6;
    for (int i = 1; i < 6; i++)
      check_output("back-to-back frame period", 32'(fall_q[base+i] - fall_q[base+i-1]), 32'(PERIOD));
    check_output("periph en_out_lo", 32'(preg[0]), 32'h66);
    check_output("periph en_pwm_hi", 32'(preg[3]), 32'h44);

    // Out-of-range address is dropped, next request still framed
    apply_stimulus(7'h05, 8'hFF, 16'h85FF, 1'b1, st);
    apply_stimulus(7'h01, 8'h77, 16'h8177, 1'b0, st);
    wait_idle();
    check_output("periph en_out_hi after drop", 32'(preg[1]), 32'h77);

    // Push coinciding with pop on an almost-full FIFO
    apply_stimulus(7'h00, 8'h01, 16'h8001, 1'b0, st);
    apply_stimulus(7'h01, 8'h02, 16'h8102, 1'b0, st);
    apply_stimulus(7'h02, 8'h03, 16'h8203, 1'b0, st);
    apply_stimulus(7'h03, 8'h04, 16'h8304, 1'b0, st);
    check_output("fill to 3 stall", 32'(st), 32'd0);
    wait_frame_done();
    repeat (CS_GAP - 1) @(negedge clk);
    apply_stimulus(7'h04, 8'h05, 16'h8405, 1'b0, st);
    check_output("push during pop stall", 32'(st), 32'd0);
    check_output("pop in same cycle as push", 32'(nCS), 32'd0);
    apply_stimulus(7'h00, 8'h06, 16'h8006, 1'b0, st);
    check_output("fourth entry accepted", 32'(st), 32'd0);
    apply_stimulus(7'h01, 8'h07, 16'h8107, 1'b0, st);
    check_output("fifth entry stalls", 32'(st), 32'd1);
    wait_idle();
    check_output("periph en_pwm_duty after overlap", 32'(preg[4]), 32'h05);

    // Reset after the 7th SCLK rise aborts the frame and empties the FIFO
    apply_stimulus(7'h03, 8'h99, 16'h8399, 1'b0, st);
    apply_stimulus(7'h00, 8'h12, 16'h8012, 1'b0, st);
    rises = 0; n = 0; ps = 1'b0;
    while (rises < 7 && n < 2000) begin
      @(negedge clk);
      if (SCLK && !ps) rises++;
      ps = SCLK;
      n++;
    end
    check_output("7 SCLK rises seen", 32'(rises), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid-frame reset nCS", 32'(nCS), 32'd1);
    check_output("mid-frame reset SCLK", 32'(SCLK), 32'd0);
    check_output("mid-frame reset req_ready", 32'(req_ready), 32'd1);
    check_output("mid-frame reset busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    check_output("aborted frame left en_pwm_hi", 32'(preg[3]), 32'h04);
    check_output("flushed entry left en_out_lo", 32'(preg[0]), 32'h06);
    apply_stimulus(7'h02, 8'h5A, 16'h825A, 1'b0, st);
    wait_idle();
    check_output("periph en_pwm_lo after reset", 32'(preg[2]), 32'h5A);

    // CLK_DIV=3, CS_GAP=4 instance
    @(negedge clk);
    req_valid3 = 1'b1; req_addr3 = 7'h02; req_data3 = 8'h3C;
    check_output("div3 req_ready", 32'(req_ready3), 32'd1);
    exp3_q.push_back('{1'b0, 16'h823C});
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy3 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check_output("div3 busy drops", 32'(busy3), 32'd0);
    check_output("div3 periph en_pwm_lo", 32'(preg3[2]), 32'h3C);

    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check_output("div3 scoreboard drained", 32'(exp3_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
